// File: rtl/qspi_shift_reg.sv
// qspi_shift_reg: byte-wide serializer/deserializer for the QSPI data path.
// A byte is loaded in IDLE and shifted out/in 1, 2 or 4 bits per beat
// (SINGLE/DUAL/QUAD) under the drive_edge / sample_edge strobes that come
// from the clock generator. The beat counter ends the byte on the last sample.
//
// Optional feature macro: QSPI_SHIFT_LSB_FIRST_EN
//   undefined (default): MSB first, left shifts, chunk taken from the top bits.
//   defined            : LSB first, right shifts, chunk taken from the low bits,
//                        received chunks enter at the top of the rx register.
//
// Handshake: load is a request qualified by load_ready (high only in IDLE);
// a load seen while load_ready=0, or with mode=11, is dropped without effect.
// byte_done / rx_valid are single-cycle pulses, registered, appearing in the
// first IDLE cycle after the final sample_edge.

`ifndef IO_WIDTH_DEFAULT
`define IO_WIDTH_DEFAULT 4
`endif
`ifndef DIR_WRITE
`define DIR_WRITE 1'b0
`endif
`ifndef DIR_READ
`define DIR_READ 1'b1
`endif

module qspi_shift_reg #(
    parameter int IO_WIDTH = `IO_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                drive_edge,
    input  logic                sample_edge,
    input  logic [1:0]          mode,
    input  logic                dir,
    input  logic                load,
    input  logic [7:0]          tx_data,
    output logic                load_ready,
    output logic [IO_WIDTH-1:0] data_out,
    input  logic [IO_WIDTH-1:0] data_in,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    output logic                byte_done,
    output logic                busy,
    output logic                state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SINGLE  = 2'b00;
    localparam logic [1:0] MODE_DUAL    = 2'b01;
    localparam logic [1:0] MODE_INVALID = 2'b11;

    state_t     state_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [3:0] cnt_q;
    logic [1:0] mode_q;
    logic       dir_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       byte_done_q;

    logic [3:0] chunk_d;
    logic [7:0] tx_d;
    logic [7:0] rx_d;
    logic       unused_din;

    // Lines above the four QSPI data lines carry nothing into this block.
    assign unused_din = ^data_in;

    // Per latched mode: the chunk presented to the io stage, and the shifted
    // tx / rx register values applied on drive_edge / sample_edge.
    always_comb begin
        chunk_d = 4'b0000;
        tx_d    = tx_q;
        rx_d    = rx_q;
        case (mode_q)
            MODE_SINGLE: begin
`ifdef QSPI_SHIFT_LSB_FIRST_EN
                chunk_d = {3'b000, tx_q[0]};
                tx_d    = {1'b0, tx_q[7:1]};
                rx_d    = {data_in[0], rx_q[7:1]};
`else
                chunk_d = {3'b000, tx_q[7]};
                tx_d    = {tx_q[6:0], 1'b0};
                rx_d    = {rx_q[6:0], data_in[0]};
`endif
            end
            MODE_DUAL: begin
`ifdef QSPI_SHIFT_LSB_FIRST_EN
                chunk_d = {2'b00, tx_q[1:0]};
                tx_d    = {2'b00, tx_q[7:2]};
                rx_d    = {data_in[1:0], rx_q[7:2]};
`else
                chunk_d = {2'b00, tx_q[7:6]};
                tx_d    = {tx_q[5:0], 2'b00};
                rx_d    = {rx_q[5:0], data_in[1:0]};
`endif
            end
            default: begin
                // QUAD; mode 11 is never latched so it cannot reach here.
`ifdef QSPI_SHIFT_LSB_FIRST_EN
                chunk_d = tx_q[3:0];
                tx_d    = {4'b0000, tx_q[7:4]};
                rx_d    = {data_in[3:0], rx_q[7:4]};
`else
                chunk_d = tx_q[7:4];
                tx_d    = {tx_q[3:0], 4'b0000};
                rx_d    = {rx_q[3:0], data_in[3:0]};
`endif
            end
        endcase
    end

    // Drive the io stage only while shifting; unused lines stay low.
    always_comb begin
        data_out = '0;
        if (state_q == SHIFT) begin
            data_out[3:0] = chunk_d;
        end
    end

    // IDLE/SHIFT controller with registered completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            cnt_q       <= 4'd0;
            mode_q      <= 2'b00;
            dir_q       <= `DIR_WRITE;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            byte_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load && (mode != MODE_INVALID)) begin
                        tx_q    <= tx_data;
                        rx_q    <= 8'h00;
                        mode_q  <= mode;
                        dir_q   <= dir;
                        state_q <= SHIFT;
                        case (mode)
                            MODE_SINGLE: cnt_q <= 4'd8;
                            MODE_DUAL:   cnt_q <= 4'd4;
                            default:     cnt_q <= 4'd2;
                        endcase
                    end
                end
                SHIFT: begin
                    if (drive_edge) begin
                        tx_q <= tx_d;
                    end
                    if (sample_edge) begin
                        rx_q  <= rx_d;
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q     <= IDLE;
                            byte_done_q <= 1'b1;
                            if (dir_q == `DIR_READ) begin
                                rx_data_q  <= rx_d;
                                rx_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == SHIFT);
    assign state_dbg  = state_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign byte_done  = byte_done_q;

endmodule

// File: tb/tb_qspi_shift_reg.sv
// Bench for qspi_shift_reg: directed literal cases plus randomized traffic
// compared every cycle against a byte-level model (drive count / sample list).

`timescale 1ns/1ps

module tb_qspi_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       drive_edge, sample_edge, dir, load;
    logic [1:0] mode;
    logic [7:0] tx_data;
    logic       load_ready;
    logic [3:0] data_out;
    logic [3:0] data_in;
    logic [7:0] rx_data;
    logic       rx_valid, byte_done, busy, state_dbg;

    int errors = 0;
    int checks = 0;
    int rv_seen = 0;
    int bd_seen = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    qspi_shift_reg #(.IO_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .drive_edge(drive_edge), .sample_edge(sample_edge),
        .mode(mode), .dir(dir), .load(load), .tx_data(tx_data), .load_ready(load_ready),
        .data_out(data_out), .data_in(data_in), .rx_data(rx_data), .rx_valid(rx_valid),
        .byte_done(byte_done), .busy(busy), .state_dbg(state_dbg)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];
    int         samp_q[$];
    bit         m_busy = 0;
    int         m_tx, m_n, m_drives, m_done_cnt = 0;
    bit         m_dir;
    logic [7:0] m_rx_data = 8'h00;
    bit         m_rx_valid = 0, m_byte_done = 0;

    function automatic int assemble();
        int acc = 0;
        foreach (samp_q[i]) begin
`ifdef QSPI_SHIFT_LSB_FIRST_EN
            acc = (acc >> m_n) | (samp_q[i] << (8 - m_n));
`else
            acc = ((acc << m_n) | samp_q[i]) & 255;
`endif
        end
        return acc;
    endfunction

    function automatic logic [3:0] exp_dout();
        int mask = (1 << m_n) - 1;
        if (!m_busy || m_drives >= 8 / m_n) return 4'h0;
`ifdef QSPI_SHIFT_LSB_FIRST_EN
        return 4'((m_tx >> (m_n * m_drives)) & mask);
`else
        return 4'((m_tx >> (8 - m_n * (m_drives + 1))) & mask);
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_rx_data = 8'h00; m_rx_valid = 0; m_byte_done = 0;
            samp_q.delete();
        end else begin
            m_rx_valid = 0; m_byte_done = 0;
            if (!m_busy) begin
                if (load && mode != 2'b11) begin
                    m_busy = 1; m_tx = tx_data; m_n = 1 << mode; m_dir = dir;
                    m_drives = 0; samp_q.delete();
                end
            end else begin
                if (drive_edge) m_drives++;
                if (sample_edge) begin
                    samp_q.push_back(int'(data_in) & ((1 << m_n) - 1));
                    if (samp_q.size() == 8 / m_n) begin
                        m_busy = 0; m_byte_done = 1; m_done_cnt++;
                        if (m_dir) begin
                            m_rx_data = 8'(assemble());
                            m_rx_valid = 1;
                            exp_q.push_back(m_rx_data);
                        end
                    end
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("load_ready", 32'(load_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("data_out", 32'(data_out), 32'(exp_dout()));
            chk("byte_done", 32'(byte_done), 32'(m_byte_done));
            chk("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
            chk("rx_data", 32'(rx_data), 32'(m_rx_data));
            if (rx_valid) begin
                rv_seen++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_sb: got=%0h expected=none", rx_data);
                end else begin
                    chk("rx_sb", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (byte_done) bd_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_byte(input logic [1:0] md, input logic dr, input logic [7:0] tx);
        load = 1'b1; mode = md; dir = dr; tx_data = tx;
        tick();
        load = 1'b0;
    endtask

    task automatic beat(input logic d, input logic s, input logic [3:0] din);
        drive_edge = d; sample_edge = s; data_in = din;
        tick();
        drive_edge = 1'b0; sample_edge = 1'b0;
    endtask

    // Collect data_out bits over a byte, first chunk ending up in the MSBs.
    task automatic run_byte(input int n, output logic [7:0] seq);
        seq = 8'h00;
        for (int i = 0; i < 8 / n; i++) begin
            chk("unused_lines", 32'(data_out >> n), 32'h0);
            seq = 8'((seq << n) | (data_out & 4'((1 << n) - 1)));
            beat(1'b1, 1'b1, 4'($urandom_range(0, 15)));
        end
    endtask

    logic [7:0] seq;
    int rv0, bd0;

    initial begin
        reset = 1'b1; drive_edge = 0; sample_edge = 0; dir = 0; load = 0;
        mode = 2'b00; tx_data = 8'h00; data_in = 4'h0;
        tick(); tick();
        chk("reset_load_ready", 32'(load_ready), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_data_out", 32'(data_out), 32'h0);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        reset = 1'b0;
        tick();

`ifndef QSPI_SHIFT_LSB_FIRST_EN
        // SINGLE write A5
        rv0 = rv_seen;
        load_byte(2'b00, 1'b0, 8'hA5);
        run_byte(1, seq);
        chk("a5_byte_done", 32'(byte_done), 32'h1);
        chk("a5_seq", 32'(seq), 32'hA5);
        tick();
        chk("a5_no_rx_valid", 32'(rv_seen - rv0), 32'h0);
        // QUAD read C,3
        load_byte(2'b10, 1'b1, 8'h00);
        beat(1'b0, 1'b1, 4'hC);
        beat(1'b0, 1'b1, 4'h3);
        chk("quad_rx_data", 32'(rx_data), 32'hC3);
        chk("quad_rx_valid", 32'(rx_valid), 32'h1);
        chk("quad_byte_done", 32'(byte_done), 32'h1);
        tick();
        chk("quad_rx_valid_off", 32'(rx_valid), 32'h0);
        chk("quad_byte_done_off", 32'(byte_done), 32'h0);
        // DUAL write 1B
        load_byte(2'b01, 1'b0, 8'h1B);
        run_byte(2, seq);
        chk("dual_seq", 32'(seq), 32'h1B);
        tick();
`else
        load_byte(2'b00, 1'b0, 8'h01);
        run_byte(1, seq);
        chk("lsb_seq", 32'(seq), 32'h80);
        tick();
`endif

        // invalid mode, then load while shifting
        load_byte(2'b11, 1'b0, 8'hFF);
        chk("m11_load_ready", 32'(load_ready), 32'h1);
        chk("m11_busy", 32'(busy), 32'h0);
        load_byte(2'b00, 1'b0, 8'h81);
        load_byte(2'b10, 1'b1, 8'h00);
        seq = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seq = {seq[6:0], data_out[0]};
            beat(1'b1, 1'b1, 4'h0);
        end
        chk("inflight_seq", 32'(seq), 32'h81);
        tick();

        // reset mid-byte
        bd0 = bd_seen;
        load_byte(2'b00, 1'b0, 8'h3C);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 4'h0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_data_out", 32'(data_out), 32'h0);
        chk("midrst_load_ready", 32'(load_ready), 32'h1);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("midrst_no_byte_done", 32'(bd_seen - bd0), 32'h0);
        load_byte(2'b00, 1'b0, 8'hFF);
        run_byte(1, seq);
        chk("ff_seq", 32'(seq), 32'hFF);
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            load        = ($urandom_range(0, 5) == 0);
            mode        = 2'($urandom_range(0, 3));
            dir         = 1'($urandom_range(0, 1));
            tx_data     = 8'($urandom_range(0, 255));
            drive_edge  = 1'($urandom_range(0, 1));
            sample_edge = ($urandom_range(0, 2) == 0);
            data_in     = 4'($urandom_range(0, 15));
            tick();
        end
        load = 0; drive_edge = 0; sample_edge = 0;
        tick();
        chk("random_bytes_done", 32'(m_done_cnt >= 30), 32'h1);
        chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
